// File: rtl/shift_add_mult_ctrl_if.sv
// Control bundle between the shift-and-add sequencer and its datapath.
// slave: sequencer side (start/b_lsb in, controls out); master: datapath side.
interface shift_add_mult_ctrl_if;
  logic       start;
  logic       b_lsb;
  logic       clr_out;
  logic       ld_A;
  logic       ld_B;
  logic       add_en;
  logic [1:0] sh_ctrl;
  logic       ld_out;
  logic       busy;
  logic       done;
`ifdef SHIFT_ADD_MULT_ABORT_EN
  logic       abort;
  logic       aborted;

  modport master (
    output start, b_lsb, abort,
    input  clr_out, ld_A, ld_B, add_en,
    input  sh_ctrl, ld_out, busy, done,
    input  aborted
  );

  modport slave (
    input  start, b_lsb, abort,
    output clr_out, ld_A, ld_B, add_en,
    output sh_ctrl, ld_out, busy, done,
    output aborted
  );
`else
  modport master (
    output start, b_lsb,
    input  clr_out, ld_A, ld_B, add_en,
    input  sh_ctrl, ld_out, busy, done
  );

  modport slave (
    input  start, b_lsb,
    output clr_out, ld_A, ld_B, add_en,
    output sh_ctrl, ld_out, busy, done
  );
`endif
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// Shift-and-add multiplier sequencer: clear, load, WIDTH add/shift steps, store, done.
// Ports: clk; rst (async, active-low); bus (slave): start, b_lsb in;
//   clr_out, ld_A, ld_B, add_en, sh_ctrl, ld_out, busy, done out.
//   SHIFT_ADD_MULT_ABORT_EN adds abort in / aborted out and an ABORT state.
module shift_add_mult_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  shift_add_mult_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    LOAD  = 3'd2,
    ADD   = 3'd3,
    SHIFT = 3'd4,
    STORE = 3'd5,
    DONE  = 3'd6
`ifdef SHIFT_ADD_MULT_ABORT_EN
    ,
    ABORT = 3'd7
`endif
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic             last;

  logic       clr;
  logic       ld;
  logic       add;
  logic [1:0] sh;
  logic       ldo;
  logic       dn;
`ifdef SHIFT_ADD_MULT_ABORT_EN
  logic       abt;
`endif

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    clr     = 1'b0;
    ld      = 1'b0;
    add     = 1'b0;
    sh      = 2'b00;
    ldo     = 1'b0;
    dn      = 1'b0;
`ifdef SHIFT_ADD_MULT_ABORT_EN
    abt     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (bus.start) state_n = INIT;
      end
      INIT: begin
        clr     = 1'b1;
        state_n = LOAD;
      end
      LOAD: begin
        ld      = 1'b1;
        cnt_n   = '0;
        state_n = ADD;
      end
      ADD: begin
        add     = bus.b_lsb;
        state_n = SHIFT;
      end
      SHIFT: begin
        sh      = 2'b01;
        cnt_n   = cnt + CNT_W'(1);
        state_n = last ? STORE : ADD;
      end
      STORE: begin
        ldo     = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        dn      = 1'b1;
        state_n = IDLE;
      end
`ifdef SHIFT_ADD_MULT_ABORT_EN
      ABORT: begin
        clr     = 1'b1;
        abt     = 1'b1;
        state_n = IDLE;
      end
`endif
      default: begin
        state_n = IDLE;
      end
    endcase
`ifdef SHIFT_ADD_MULT_ABORT_EN
    // Abort overrides every normal transition once an op is in flight.
    if (bus.abort && state != IDLE && state != DONE) begin
      state_n = ABORT;
    end
`endif
  end

  assign bus.clr_out = clr;
  assign bus.ld_A    = ld;
  assign bus.ld_B    = ld;
  assign bus.add_en  = add;
  assign bus.sh_ctrl = sh;
  assign bus.ld_out  = ldo;
  assign bus.done    = dn;
  assign bus.busy    = (state != IDLE);
`ifdef SHIFT_ADD_MULT_ABORT_EN
  assign bus.aborted = abt;
`endif

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Scoreboard bench for shift_add_mult_ctrl with a behavioural datapath.
// Expected product is plain A*B; timing follows the start-edge latencies.
module tb_shift_add_mult_ctrl;
  localparam int W = 4;

  logic clk;
  logic rst;

  logic [W-1:0]   a_in;
  logic [W-1:0]   b_in;
  logic [W-1:0]   a_reg = '0;
  logic [W-1:0]   b_reg = '0;
  logic [W:0]     acc   = '0;
  logic [2*W-1:0] prod  = '0;

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int busy_until = -1;
  int free_at = 0;
  int abort_e = -100;
  int adds = 0;

  typedef struct {
    logic [2*W-1:0] prod;
    int             adds;
    int             ld_e;
    int             done_e;
  } exp_t;

  exp_t q[$];

  shift_add_mult_ctrl_if bus ();

  shift_add_mult_ctrl #(
    .WIDTH (W),
    .CNT_W (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath the controller drives.
  always @(posedge clk) begin
    if (bus.clr_out) acc <= '0;
    if (bus.ld_A) a_reg <= a_in;
    if (bus.ld_B) b_reg <= b_in;
    if (bus.add_en) acc <= acc + {1'b0, a_reg};
    if (bus.sh_ctrl == 2'b01) {acc, b_reg} <= {acc, b_reg} >> 1;
    if (bus.ld_out) prod <= {acc[W-1:0], b_reg};
  end
  assign bus.b_lsb = b_reg[0];

  // Reference model: decides at each edge whether start (or abort) is taken.
  always @(posedge clk or negedge rst) begin : model
    exp_t e;
    if (!rst) begin
      busy_until = -1;
      free_at    = 0;
    end else begin
      edge_n = edge_n + 1;
`ifdef SHIFT_ADD_MULT_ABORT_EN
      if (bus.abort && edge_n <= busy_until) begin
        abort_e    = edge_n;
        busy_until = edge_n;
        free_at    = edge_n + 2;
      end else
`endif
      if (bus.start && edge_n >= free_at) begin
        e.prod     = (2*W)'(a_in) * (2*W)'(b_in);
        e.adds     = $countones(b_in);
        e.ld_e     = edge_n + 2*W + 2;
        e.done_e   = edge_n + 2*W + 3;
        q.push_back(e);
        busy_until = edge_n + 2*W + 3;
        free_at    = edge_n + 2*W + 5;
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @edge %0d: got %0h expected %0h",
               name, edge_n, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic exp_ld;
    logic exp_done;
    int   n_on;
    if (!rst) begin
      chk("reset_outputs",
          32'({bus.clr_out, bus.ld_A, bus.ld_B, bus.add_en,
               bus.sh_ctrl, bus.ld_out, bus.busy, bus.done}),
          32'd0);
      q.delete();
      adds = 0;
    end else begin
      chk("busy", 32'(bus.busy), 32'(edge_n <= busy_until));
      n_on = $countones({bus.clr_out, bus.ld_A | bus.ld_B,
                         bus.add_en, |bus.sh_ctrl, bus.ld_out});
      chk("one_control", 32'(n_on <= 1), 32'd1);
      chk("ld_pair", 32'(bus.ld_A), 32'(bus.ld_B));
      chk("sh_legal", 32'(bus.sh_ctrl[1]), 32'd0);
      if (bus.add_en) adds++;
`ifdef SHIFT_ADD_MULT_ABORT_EN
      chk("aborted", 32'(bus.aborted), 32'(edge_n == abort_e));
      if (edge_n == abort_e) begin
        if (q.size() > 0) void'(q.pop_front());
        adds = 0;
      end
`endif
      exp_ld   = 1'b0;
      exp_done = 1'b0;
      if (q.size() > 0) begin
        exp_ld   = (edge_n == q[0].ld_e);
        exp_done = (edge_n == q[0].done_e);
      end
      chk("ld_out", 32'(bus.ld_out), 32'(exp_ld));
      chk("done", 32'(bus.done), 32'(exp_done));
      if (exp_done) begin
        chk("product", 32'(prod), 32'(q[0].prod));
        chk("add_count", adds, q[0].adds);
        void'(q.pop_front());
        adds = 0;
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) break;
    end
  endtask

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input bit pulse);
    a_in = a;
    b_in = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (pulse) bus.start = 1'b0;
    wait_done();
    bus.start = 1'b0;
    repeat (1 + $urandom_range(0, 2)) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus.start = 1'b0;
    a_in = '0;
    b_in = '0;
`ifdef SHIFT_ADD_MULT_ABORT_EN
    bus.abort = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    run_op(4'd7, 4'hB, 1'b0);
    run_op(4'd9, 4'h0, 1'b1);
    run_op(4'hF, 4'hF, 1'b0);
    run_op(4'h0, 4'hF, 1'b1);

    // Back-to-back ops with start held high.
    a_in = 4'd3;
    b_in = 4'd5;
    bus.start = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_done();
      a_in = W'($urandom_range(0, 15));
      b_in = W'($urandom_range(0, 15));
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;

    // Extra start pulses while busy must be ignored.
    a_in = 4'd5;
    b_in = 4'd6;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done();
    @(posedge clk);
    #1;

    // Reset during iteration 2.
    a_in = 4'd13;
    b_in = 4'd7;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(4'd11, 4'd13, 1'b1);

`ifdef SHIFT_ADD_MULT_ABORT_EN
    a_in = 4'd6;
    b_in = 4'd9;
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.abort = 1'b1;
    @(posedge clk);
    #1 bus.abort = 1'b0;
    @(posedge clk);
    #1;
    run_op(4'd2, 4'd3, 1'b0);
`endif

    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom_range(0, 15)),
             W'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
